gpio_ctrl: RTL

//  Parametrised memory-mapped GPIO peripheral; next generation of the single 8-bit GPIO output register.

---
 rtl/gpio_pkg.sv | 20 ++
 rtl/gpio_ctrl_if.sv | 14 +
 rtl/gpio_in_cond.sv | 58 +++++
 rtl/gpio_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: register index enum and byte offsets of the GPIO register window
package gpio_pkg;

    typedef enum logic [2:0] {
        REG_DATA_OUT   = 3'd0,
        REG_DATA_IN    = 3'd1,
        REG_DIR        = 3'd2,
        REG_IRQ_EN     = 3'd3,
        REG_IRQ_STATUS = 3'd4,
        REG_EDGE_SEL   = 3'd5
    } gpio_reg_e;

    localparam int unsigned GPIO_DATA_OUT_OFS   = int'(REG_DATA_OUT)   << 2;
    localparam int unsigned GPIO_DATA_IN_OFS    = int'(REG_DATA_IN)    << 2;
    localparam int unsigned GPIO_DIR_OFS        = int'(REG_DIR)        << 2;
    localparam int unsigned GPIO_IRQ_EN_OFS     = int'(REG_IRQ_EN)     << 2;
    localparam int unsigned GPIO_IRQ_STATUS_OFS = int'(REG_IRQ_STATUS) << 2;
    localparam int unsigned GPIO_EDGE_SEL_OFS   = int'(REG_EDGE_SEL)   << 2;

endpackage

// File: rtl/gpio_ctrl_if.sv
// gpio_ctrl_if: core data bus slice seen by the GPIO peripheral (select, offset, write, read data)
interface gpio_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 5
);
    logic                  sel_i;
    logic [ADDR_BITS-1:0]  addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  we_i;
    logic [DATA_WIDTH-1:0] rdata_o;

    modport master (output sel_i, addr_i, wdata_i, we_i, input rdata_o);
    modport slave  (input sel_i, addr_i, wdata_i, we_i, output rdata_o);
endinterface

// File: rtl/gpio_in_cond.sv
// gpio_in_cond: one pin's input path - synchroniser, optional debounce (GPIO_DEBOUNCE_EN), edge detect
module gpio_in_cond
`ifdef GPIO_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 4
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    input  logic rise_sel_i,
    output logic level_o,
    output logic event_o
);
    logic s1_q, s2_q, prev_q;

    // two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk or negedge reset)
        if (!reset) {s1_q, s2_q} <= 2'b00;
        else        {s1_q, s2_q} <= {pin_i, s1_q};

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done;

    assign done = cnt_q == CW'(DEBOUNCE_CYCLES - 1);

    // filtered level follows s2 only after it has differed for DEBOUNCE_CYCLES cycles in a row
    always_comb begin
        cnt_d  = (s2_q == filt_q || done) ? '0 : cnt_q + 1'b1;
        filt_d = (s2_q != filt_q && done) ? s2_q : filt_q;
    end

    // debounce state
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end

    assign level_o = filt_q;
`else
    assign level_o = s2_q;
`endif

    // previous conditioned level for edge detection
    always_ff @(posedge clk or negedge reset)
        if (!reset) prev_q <= 1'b0;
        else        prev_q <= level_o;

    assign event_o = rise_sel_i ? (level_o & ~prev_q) : (~level_o & prev_q);
endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO with direction, synchronised inputs and W1C edge interrupts;
// define GPIO_DEBOUNCE_EN to insert a per-pin debounce filter in the input path
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_PINS        = 8,
    parameter int ADDR_BITS       = 5,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    gpio_ctrl_if.slave          bus,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [NUM_PINS-1:0] gpio_out,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic                irq_o
);
    localparam int WB = ADDR_BITS - 2;

    if (NUM_PINS < 1 || NUM_PINS > DATA_WIDTH || ADDR_BITS < 5 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("gpio_ctrl: illegal parameter combination");
    end

    logic [NUM_PINS-1:0] data_out_q, data_out_d;
    logic [NUM_PINS-1:0] dir_q, dir_d;
    logic [NUM_PINS-1:0] irq_en_q, irq_en_d;
    logic [NUM_PINS-1:0] status_q, status_d;
    logic [NUM_PINS-1:0] edge_sel_q, edge_sel_d;
    logic [NUM_PINS-1:0] level_w, event_w, wr, rd_pins;
    logic [WB-1:0]       word;
    logic hit_dout, hit_din, hit_dir, hit_en, hit_stat, hit_esel, we;
    logic unused_bus;

    assign word       = bus.addr_i[ADDR_BITS-1:2];
    assign wr         = bus.wdata_i[NUM_PINS-1:0];
    assign we         = bus.we_i;
    assign unused_bus = ^{bus.addr_i[1:0], bus.wdata_i};

    assign hit_dout = bus.sel_i && word == WB'(GPIO_DATA_OUT_OFS   >> 2);
    assign hit_din  = bus.sel_i && word == WB'(GPIO_DATA_IN_OFS    >> 2);
    assign hit_dir  = bus.sel_i && word == WB'(GPIO_DIR_OFS        >> 2);
    assign hit_en   = bus.sel_i && word == WB'(GPIO_IRQ_EN_OFS     >> 2);
    assign hit_stat = bus.sel_i && word == WB'(GPIO_IRQ_STATUS_OFS >> 2);
    assign hit_esel = bus.sel_i && word == WB'(GPIO_EDGE_SEL_OFS   >> 2);

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
`ifdef GPIO_DEBOUNCE_EN
        gpio_in_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
`else
        gpio_in_cond u_cond (
`endif
            .clk        (clk),
            .reset      (reset),
            .pin_i      (gpio_in[i]),
            .rise_sel_i (edge_sel_q[i]),
            .level_o    (level_w[i]),
            .event_o    (event_w[i])
        );
    end

    // register writes; status clears on written ones but a same-cycle edge event wins
    always_comb begin
        data_out_d = (we && hit_dout) ? wr : data_out_q;
        dir_d      = (we && hit_dir)  ? wr : dir_q;
        irq_en_d   = (we && hit_en)   ? wr : irq_en_q;
        edge_sel_d = (we && hit_esel) ? wr : edge_sel_q;
        status_d   = (status_q & ~((we && hit_stat) ? wr : '0)) | event_w;
    end

    // register state
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            data_out_q <= '0;
            dir_q      <= '0;
            irq_en_q   <= '0;
            status_q   <= '0;
            edge_sel_q <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irq_en_q   <= irq_en_d;
            status_q   <= status_d;
            edge_sel_q <= edge_sel_d;
        end

    // combinational read mux; unmapped offsets and deselected bus read zero
    always_comb begin
        rd_pins = hit_dout ? data_out_q :
                  hit_din  ? level_w    :
                  hit_dir  ? dir_q      :
                  hit_en   ? irq_en_q   :
                  hit_stat ? status_q   :
                  hit_esel ? edge_sel_q : '0;
    end

    assign bus.rdata_o = DATA_WIDTH'(rd_pins);
    assign gpio_out    = data_out_q;
    assign gpio_oe     = dir_q;
    assign irq_o       = |(status_q & irq_en_q);
endmodule
